// File: rtl/mk8_avm_pkg.sv
// Shared definitions for the Mk8 Avalon-MM PIO initiator.
//   state_e : FSM states of mk8_avm_pio_master
//   op_e    : command operation encoding (cmd_write)
//   PIO_*   : word offsets of the standard Mk8 PIO slave registers
package mk8_avm_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR     = 3'd1,
    RD     = 3'd2,
    RDWAIT = 3'd3,
    RESP   = 3'd4
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  localparam logic [2:0] PIO_DATA      = 3'd0;
  localparam logic [2:0] PIO_DIRECTION = 3'd1;
  localparam logic [2:0] PIO_IRQMASK   = 3'd2;
  localparam logic [2:0] PIO_EDGECAP   = 3'd3;
  localparam logic [2:0] PIO_OUTSET    = 3'd4;
  localparam logic [2:0] PIO_OUTCLR    = 3'd5;

endpackage

// File: rtl/mk8_avm_pio_master.sv
// Avalon-MM initiator for Mk8 PIO slaves. Runs one Avalon transaction per
// command accepted on the cmd_* port and returns one response on rsp_*.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   cmd_valid/ready     command handshake; cmd_write, cmd_address, cmd_writedata
//   rsp_valid/ready     response handshake; rsp_readdata (0 for writes), rsp_error
//   avm_*               Avalon-MM initiator (active-low read/write strobes)
//   busy                high whenever the FSM is not in IDLE
//
// Parameters: ADDR_W (word address width), READ_LATENCY (0..3 fixed slave
// latency), TIMEOUT_CYCLES (waitrequest cycles tolerated).
//
// Build option: define MK8_AVM_TIMEOUT_EN to abort a transaction after
// TIMEOUT_CYCLES stalled strobe cycles (rsp_error=1). Without it the FSM
// waits on waitrequest indefinitely and rsp_error is always 0.
module mk8_avm_pio_master
  import mk8_avm_pkg::*;
#(
  parameter int ADDR_W         = 3,
  parameter int READ_LATENCY   = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_address,
  input  logic [31:0]       cmd_writedata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_readdata,
  output logic              rsp_error,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_write_n,
  output logic              avm_read_n,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest,
  output logic              busy
);

  // Cycles still to wait in RDWAIT after the read was accepted.
  localparam logic [1:0] LAT_M1 = (READ_LATENCY > 0) ? 2'(READ_LATENCY - 1) : 2'd0;

  state_e              state_q, state_d;
  logic [1:0]          lat_cnt_q, lat_cnt_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [31:0]         rsp_readdata_q, rsp_readdata_d;
  logic                rsp_error_q, rsp_error_d;
  logic [ADDR_W-1:0]   avm_address_q, avm_address_d;
  logic                avm_chipselect_q, avm_chipselect_d;
  logic                avm_write_n_q, avm_write_n_d;
  logic                avm_read_n_q, avm_read_n_d;
  logic [31:0]         avm_writedata_q, avm_writedata_d;
  logic                busy_q, busy_d;
  logic                timeout_hit;
  op_e                 cmd_op;

  assign cmd_op = op_e'(cmd_write);

`ifdef MK8_AVM_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // The stalled cycle that would make the count reach TIMEOUT_CYCLES aborts.
  assign timeout_hit = avm_waitrequest && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    // NOTE: every _d defaults to its _q first, so no path through the case
    // leaves a variable unassigned and no latch is inferred.
    state_d          = state_q;
    lat_cnt_d        = lat_cnt_q;
    cmd_ready_d      = cmd_ready_q;
    rsp_valid_d      = rsp_valid_q;
    rsp_readdata_d   = rsp_readdata_q;
    rsp_error_d      = rsp_error_q;
    avm_address_d    = avm_address_q;
    avm_chipselect_d = avm_chipselect_q;
    avm_write_n_d    = avm_write_n_q;
    avm_read_n_d     = avm_read_n_q;
    avm_writedata_d  = avm_writedata_q;
    busy_d           = busy_q;
`ifdef MK8_AVM_TIMEOUT_EN
    to_cnt_d         = to_cnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cmd_ready_d      = 1'b0;
          busy_d           = 1'b1;
          avm_address_d    = cmd_address;
          avm_writedata_d  = cmd_writedata;
          avm_chipselect_d = 1'b1;
`ifdef MK8_AVM_TIMEOUT_EN
          to_cnt_d         = '0;
`endif
          if (cmd_op == OP_WRITE) begin
            avm_write_n_d = 1'b0;
            state_d       = WR;
          end else begin
            avm_read_n_d  = 1'b0;
            state_d       = RD;
          end
        end
      end

      WR, RD: begin
        if (!avm_waitrequest || timeout_hit) begin
          avm_chipselect_d = 1'b0;
          avm_write_n_d    = 1'b1;
          avm_read_n_d     = 1'b1;
        end
        if (timeout_hit) begin
          rsp_valid_d    = 1'b1;
          rsp_readdata_d = '0;
          rsp_error_d    = 1'b1;
          state_d        = RESP;
        end else if (!avm_waitrequest) begin
          rsp_error_d = 1'b0;
          if (state_q == WR) begin
            rsp_valid_d    = 1'b1;
            rsp_readdata_d = '0;
            state_d        = RESP;
          end else if (READ_LATENCY == 0) begin
            rsp_valid_d    = 1'b1;
            rsp_readdata_d = avm_readdata;
            state_d        = RESP;
          end else begin
            lat_cnt_d = LAT_M1;
            state_d   = RDWAIT;
          end
        end
`ifdef MK8_AVM_TIMEOUT_EN
        else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
`endif
      end

      RDWAIT: begin
        // Data is sampled exactly READ_LATENCY edges after the accepting edge.
        if (lat_cnt_q == 2'd0) begin
          rsp_valid_d    = 1'b1;
          rsp_readdata_d = avm_readdata;
          state_d        = RESP;
        end else begin
          lat_cnt_d = lat_cnt_q - 2'd1;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= IDLE;
      lat_cnt_q        <= 2'd0;
      cmd_ready_q      <= 1'b1;
      rsp_valid_q      <= 1'b0;
      rsp_readdata_q   <= '0;
      rsp_error_q      <= 1'b0;
      avm_address_q    <= '0;
      avm_chipselect_q <= 1'b0;
      avm_write_n_q    <= 1'b1;
      avm_read_n_q     <= 1'b1;
      avm_writedata_q  <= '0;
      busy_q           <= 1'b0;
`ifdef MK8_AVM_TIMEOUT_EN
      to_cnt_q         <= '0;
`endif
    end else begin
      state_q          <= state_d;
      lat_cnt_q        <= lat_cnt_d;
      cmd_ready_q      <= cmd_ready_d;
      rsp_valid_q      <= rsp_valid_d;
      rsp_readdata_q   <= rsp_readdata_d;
      rsp_error_q      <= rsp_error_d;
      avm_address_q    <= avm_address_d;
      avm_chipselect_q <= avm_chipselect_d;
      avm_write_n_q    <= avm_write_n_d;
      avm_read_n_q     <= avm_read_n_d;
      avm_writedata_q  <= avm_writedata_d;
      busy_q           <= busy_d;
`ifdef MK8_AVM_TIMEOUT_EN
      to_cnt_q         <= to_cnt_d;
`endif
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_readdata   = rsp_readdata_q;
  assign rsp_error      = rsp_error_q;
  assign avm_address    = avm_address_q;
  assign avm_chipselect = avm_chipselect_q;
  assign avm_write_n    = avm_write_n_q;
  assign avm_read_n     = avm_read_n_q;
  assign avm_writedata  = avm_writedata_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_mk8_avm_pio_master.sv
// Self-checking bench for mk8_avm_pio_master (READ_LATENCY=1).
// A table of directed commands is run through one task; hand-written
// sequences cover busy stalling, long/timeout stalls and async reset.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mk8_avm_pio_master;
  import mk8_avm_pkg::*;

`ifdef MK8_AVM_TIMEOUT_EN
  localparam int TB_TO = 8;
`else
  localparam int TB_TO = 255;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [2:0]  cmd_address;
  logic [31:0] cmd_writedata;
  logic        rsp_valid, rsp_ready, rsp_error;
  logic [31:0] rsp_readdata;
  logic [2:0]  avm_address;
  logic        avm_chipselect, avm_write_n, avm_read_n;
  logic [31:0] avm_writedata, avm_readdata;
  logic        avm_waitrequest;
  logic        busy;

  always #5 clk = ~clk;

  mk8_avm_pio_master #(
    .ADDR_W(3), .READ_LATENCY(1), .TIMEOUT_CYCLES(TB_TO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_address(cmd_address), .cmd_writedata(cmd_writedata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_readdata(rsp_readdata), .rsp_error(rsp_error),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect),
    .avm_write_n(avm_write_n), .avm_read_n(avm_read_n),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest), .busy(busy)
  );

  typedef struct {
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] wdata;
    int          waits;
    int          stall;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_strobes;
    int          exp_lat;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Slave model state
  logic [31:0] mem [8];
  int          wait_left;
  logic        prev_rd_acc, prev_wr_acc;
  logic [2:0]  prev_addr;
  logic [31:0] prev_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Slave reaction to the rising edge just passed, then waitrequest for the
  // current cycle. Read data is valid only in the cycle after acceptance.
  task automatic tick();
    if (prev_rd_acc) avm_readdata = mem[prev_addr];
    else             avm_readdata = 32'hDEAD_BEEF;
    if (prev_wr_acc) mem[prev_addr] = prev_wdata;
    if (avm_chipselect && (!avm_write_n || !avm_read_n) && wait_left > 0) begin
      avm_waitrequest = 1'b1;
      wait_left--;
    end else begin
      avm_waitrequest = 1'b0;
    end
    prev_rd_acc = avm_chipselect && !avm_read_n  && !avm_waitrequest;
    prev_wr_acc = avm_chipselect && !avm_write_n && !avm_waitrequest;
    prev_addr   = avm_address;
    prev_wdata  = avm_writedata;
  endtask

  task automatic step();
    @(negedge clk);
    tick();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " cmd_ready"},      cmd_ready,      1);
    check({tag, " rsp_valid"},      rsp_valid,      0);
    check({tag, " rsp_readdata"},   rsp_readdata,   0);
    check({tag, " rsp_error"},      rsp_error,      0);
    check({tag, " avm_chipselect"}, avm_chipselect, 0);
    check({tag, " avm_write_n"},    avm_write_n,    1);
    check({tag, " avm_read_n"},     avm_read_n,     1);
    check({tag, " avm_address"},    avm_address,    0);
    check({tag, " avm_writedata"},  avm_writedata,  0);
    check({tag, " busy"},           busy,           0);
  endtask

  // One full command: offer, observe strobes, response, optional stall.
  task automatic run_vec(input string tag, input vec_t v);
    int strobes, lat, bad, held_bad;
    logic [31:0] held;
    wait_left   = v.waits;
    rsp_ready   = (v.stall == 0);
    cmd_valid   = 1'b1;
    cmd_write   = v.wr;
    cmd_address = v.addr;
    cmd_writedata = v.wdata;
    check({tag, " cmd_ready before"}, cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    strobes = 0; lat = 0; bad = 0;
    for (int n = 1; n <= 300; n++) begin
      if (rsp_valid) begin
        lat = n;
        break;
      end
      if (avm_chipselect) begin
        strobes++;
        if (avm_address !== v.addr || avm_write_n !== !v.wr || avm_read_n !== v.wr ||
            (v.wr && avm_writedata !== v.wdata)) bad++;
      end
      if (cmd_ready !== 1'b0) bad++;
      step();
    end
    check({tag, " rsp latency"},      lat,          v.exp_lat);
    check({tag, " strobe cycles"},    strobes,      v.exp_strobes);
    check({tag, " strobe stability"}, bad,          0);
    check({tag, " rsp_readdata"},     rsp_readdata, v.exp_rdata);
    check({tag, " rsp_error"},        rsp_error,    v.exp_err);
    held = rsp_readdata;
    held_bad = 0;
    for (int i = 0; i < v.stall; i++) begin
      step();
      if (rsp_valid !== 1'b1 || rsp_readdata !== held || cmd_ready !== 1'b0 || avm_chipselect !== 1'b0)
        held_bad++;
    end
    if (v.stall > 0) check({tag, " held during stall"}, held_bad, 0);
    rsp_ready = 1'b1;
    step();
    check({tag, " rsp_valid after"}, rsp_valid, 0);
    check({tag, " cmd_ready after"}, cmd_ready, 1);
    check({tag, " busy after"},      busy,      0);
    wait_left = 0;
  endtask

  vec_t vecs [10];

  initial begin
    int stall_cnt, strobes, guard;
    logic [2:0] seen_addr;

    vecs[0] = '{1'b1, PIO_DATA,      32'h0000_00A5, 0, 0, 32'h0,          1'b0, 1, 2};
    vecs[1] = '{1'b0, PIO_DATA,      32'h0,         0, 0, 32'h0000_00A5,  1'b0, 1, 3};
    vecs[2] = '{1'b0, PIO_IRQMASK,   32'h0,         0, 0, 32'h0000_003C,  1'b0, 1, 3};
    vecs[3] = '{1'b1, PIO_OUTSET,    32'h0000_000F, 5, 0, 32'h0,          1'b0, 6, 7};
    vecs[4] = '{1'b0, PIO_OUTSET,    32'h0,         0, 4, 32'h0000_000F,  1'b0, 1, 3};
    vecs[5] = '{1'b1, PIO_OUTCLR,    32'h1234_5678, 2, 1, 32'h0,          1'b0, 3, 4};
    vecs[6] = '{1'b0, PIO_OUTCLR,    32'h0,         3, 0, 32'h1234_5678,  1'b0, 4, 6};
    vecs[7] = '{1'b1, 3'd7,          32'hFFFF_FFFF, 0, 2, 32'h0,          1'b0, 1, 2};
    vecs[8] = '{1'b0, 3'd7,          32'h0,         1, 0, 32'hFFFF_FFFF,  1'b0, 2, 4};
    vecs[9] = '{1'b0, PIO_DIRECTION, 32'h0,         0, 0, 32'h0000_0101,  1'b0, 1, 3};

    for (int i = 0; i < 8; i++) mem[i] = 32'h100 + i;
    mem[PIO_IRQMASK] = 32'h0000_003C;
    prev_rd_acc = 1'b0; prev_wr_acc = 1'b0; prev_addr = '0; prev_wdata = '0;
    wait_left = 0;
    avm_waitrequest = 1'b0;
    avm_readdata = 32'hDEAD_BEEF;
    reset_n = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = '0; cmd_writedata = '0;
    rsp_ready = 1'b1;

    repeat (3) step();
    check_reset_values("in reset");
    reset_n = 1'b1;
    repeat (3) step();
    check_reset_values("idle rsp_ready high");

    for (int i = 0; i < 10; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Command offered while busy is stalled, then executed.
    wait_left = 3;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = 3'd6; cmd_writedata = 32'h55;
    step();
    cmd_address = 3'd3; cmd_writedata = 32'h99;
    stall_cnt = 0;
    for (int n = 0; n < 40 && cmd_ready !== 1'b1; n++) begin
      stall_cnt++;
      step();
    end
    check("busy stall cycles", stall_cnt, 5);
    step();
    cmd_valid = 1'b0;
    strobes = 0; seen_addr = '0; guard = 0;
    while (rsp_valid !== 1'b1 && guard < 40) begin
      if (avm_chipselect) begin strobes++; seen_addr = avm_address; end
      guard++;
      step();
    end
    check("stalled cmd strobes", strobes, 1);
    check("stalled cmd address", seen_addr, 3);
    step();
    check("first cmd landed",  mem[6], 32'h55);
    check("stalled cmd landed", mem[3], 32'h99);
    check("stalled cmd idle",  cmd_ready, 1);

`ifdef MK8_AVM_TIMEOUT_EN
    run_vec("timeout rd", '{1'b0, PIO_DATA, 32'h0,  1000, 0, 32'h0, 1'b1, 8, 9});
    run_vec("timeout wr", '{1'b1, PIO_DATA, 32'h77, 1000, 1, 32'h0, 1'b1, 8, 9});
    check("timeout wr not landed", mem[PIO_DATA], 32'h0000_00A5);
`else
    run_vec("long wait wr", '{1'b1, PIO_EDGECAP, 32'h0000_C0DE, 20, 0, 32'h0, 1'b0, 21, 22});
    run_vec("long wait rd", '{1'b0, PIO_EDGECAP, 32'h0,         20, 0, 32'h0000_C0DE, 1'b0, 21, 23});
`endif

    // Asynchronous reset while a read is stalled in RD.
    wait_left = 3;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = PIO_IRQMASK;
    step();
    cmd_valid = 1'b0;
    step();
    check("rd strobe before reset", avm_read_n, 0);
    #2 reset_n = 1'b0;
    #1 check_reset_values("async reset");
    wait_left = 0;
    step();
    step();
    reset_n = 1'b1;
    step();
    check("no response after reset", rsp_valid, 0);
    run_vec("after reset", '{1'b0, PIO_IRQMASK, 32'h0, 0, 0, 32'h0000_003C, 1'b0, 1, 3});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
